pc_sequencer: RTL and testbench

Program-counter controller for the MIPS fetch stage. It owns the PC register and drives the select line of the 2:1 next-PC mux (pcPlusFour vs jumpAmount). It sequences sequential fetch, pipeline stalls, and jump/branch redirects. After each redirect it issues a one-cycle flush of the wrong-path fetch.

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the MIPS fetch stage.
// Owns the PC register, drives the next-PC mux select, and sequences
// sequential fetch, stalls and jump/branch redirects.
// Optional feature macro: DELAY_SLOT_EN (branch-delay-slot semantics instead
// of a one-cycle wrong-path flush after each redirect).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] STEP     = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jumpReq,
    input  logic [31:0] jumpTarget,
    input  logic        branchReq,
    input  logic [31:0] branchOffset,
    output logic [31:0] pc,
    output logic [31:0] pcPlusFour,
    output logic [31:0] jumpAmount,
    output logic        select,
    output logic        flush,
    output logic        busy
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
`ifdef DELAY_SLOT_EN
        , DELAY = 2'd3
`endif
    } seqState_t;

    seqState_t   state;
    seqState_t   nextState;
    logic [31:0] nextPc;
    logic [31:0] muxOut;
    logic [31:0] branchTarget;
    logic [31:0] jumpAligned;
    logic [31:0] redirectTarget;
    logic        advance;

`ifdef DELAY_SLOT_EN
    logic [31:0] delayTarget;
    logic [31:0] nextDelayTarget;
`endif

    // Target arithmetic: sequential, branch and word-aligned jump addresses
    always_comb begin
        pcPlusFour     = pc + STEP;
        branchTarget   = pcPlusFour + (branchOffset << 2);
        jumpAligned    = jumpTarget & ~32'h0000_0003;
        redirectTarget = jumpReq ? jumpAligned : branchTarget;
    end

    // Next-state decode, mux select and redirect target selection
    always_comb begin
        nextState  = state;
        select     = 1'b0;
        advance    = 1'b0;
        jumpAmount = redirectTarget;
`ifdef DELAY_SLOT_EN
        nextDelayTarget = delayTarget;
`endif
        case (state)
            // Releasing a stall behaves exactly like RUN in the same cycle
            RUN, STALL: begin
                if (stall) begin
                    nextState = STALL;
                end else if (jumpReq || branchReq) begin
                    advance = 1'b1;
`ifdef DELAY_SLOT_EN
                    // Delay-slot instruction fetches next; target is parked
                    nextDelayTarget = redirectTarget;
                    nextState       = DELAY;
`else
                    select    = 1'b1;
                    nextState = FLUSH;
`endif
                end else begin
                    advance   = 1'b1;
                    nextState = RUN;
                end
            end
            // Requests here come from the squashed instruction: ignored
            FLUSH: begin
                if (!stall) begin
                    advance   = 1'b1;
                    nextState = RUN;
                end
            end
`ifdef DELAY_SLOT_EN
            DELAY: begin
                jumpAmount = delayTarget;
                if (!stall) begin
                    advance   = 1'b1;
                    select    = 1'b1;
                    nextState = RUN;
                end
            end
`endif
            default: nextState = RUN;
        endcase
    end

    // Next-PC mux and hold
    always_comb begin
        muxOut = select ? jumpAmount : pcPlusFour;
        nextPc = advance ? muxOut : pc;
    end

    // PC and state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= RUN;
        end else begin
            pc    <= nextPc;
            state <= nextState;
        end
    end

`ifdef DELAY_SLOT_EN
    // Latched redirect target, discarded on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            delayTarget <= '0;
        end else begin
            delayTarget <= nextDelayTarget;
        end
    end

    assign flush = 1'b0;
`else
    assign flush = (state == FLUSH);
`endif

    assign busy = (state != RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// stimulus checked against a behavioural model. Build with DELAY_SLOT_EN
// defined to exercise the delay-slot variant.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        jumpReq;
    logic [31:0] jumpTarget;
    logic        branchReq;
    logic [31:0] branchOffset;
    logic [31:0] pc;
    logic [31:0] pcPlusFour;
    logic [31:0] jumpAmount;
    logic        select;
    logic        flush;
    logic        busy;

    int nChecks = 0;
    int nPass   = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .STEP(32'd4)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .jumpReq     (jumpReq),
        .jumpTarget  (jumpTarget),
        .branchReq   (branchReq),
        .branchOffset(branchOffset),
        .pc          (pc),
        .pcPlusFour  (pcPlusFour),
        .jumpAmount  (jumpAmount),
        .select      (select),
        .flush       (flush),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic j, input logic [31:0] jt,
                         input logic b, input logic [31:0] bo);
        stall = s; jumpReq = j; jumpTarget = jt; branchReq = b; branchOffset = bo;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        tick();
        nChecks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); else nPass++;
        nChecks++; if (flush !== 1'b0) $display("FAIL reset_flush: got %b expected 0", flush); else nPass++;
        nChecks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else nPass++;
        nChecks++; if (select !== 1'b0) $display("FAIL reset_select: got %b expected 0", select); else nPass++;
        nChecks++; if (pcPlusFour !== 32'h4) $display("FAIL reset_pcPlusFour: got %h expected %h", pcPlusFour, 32'h4); else nPass++;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            #1;
            nChecks++; if (select !== 1'b0 || flush !== 1'b0) $display("FAIL seq_ctrl%0d: got select=%b flush=%b expected 0/0", i, select, flush); else nPass++;
            tick();
            nChecks++; if (pc !== 32'(i * 4)) $display("FAIL seq_pc%0d: got %h expected %h", i, pc, 32'(i * 4)); else nPass++;
        end
    endtask

`ifndef DELAY_SLOT_EN
    task automatic test_jump();
        tick();
        nChecks++; if (pc !== 32'h10) $display("FAIL jump_start: got %h expected %h", pc, 32'h10); else nPass++;
        drive(1'b0, 1'b1, 32'h0000_0103, 1'b0, '0);
        #1;
        nChecks++; if (select !== 1'b1) $display("FAIL jump_select: got %b expected 1", select); else nPass++;
        nChecks++; if (jumpAmount !== 32'h100) $display("FAIL jump_amount: got %h expected %h", jumpAmount, 32'h100); else nPass++;
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        nChecks++; if (pc !== 32'h100 || flush !== 1'b1) $display("FAIL jump_land: got pc=%h flush=%b expected 100/1", pc, flush); else nPass++;
        tick();
        nChecks++; if (pc !== 32'h104 || flush !== 1'b0) $display("FAIL jump_after: got pc=%h flush=%b expected 104/0", pc, flush); else nPass++;
    endtask

    task automatic test_branch();
        drive(1'b0, 1'b1, 32'h1C, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        nChecks++; if (pc !== 32'h20) $display("FAIL br_start: got %h expected %h", pc, 32'h20); else nPass++;
        drive(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFE);
        #1;
        nChecks++; if (jumpAmount !== 32'h1C || select !== 1'b1) $display("FAIL br_target: got %h/%b expected 1c/1", jumpAmount, select); else nPass++;
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        nChecks++; if (pc !== 32'h1C || flush !== 1'b1) $display("FAIL br_land: got pc=%h flush=%b expected 1c/1", pc, flush); else nPass++;
        tick();
        drive(1'b0, 1'b1, 32'h200, 1'b1, 32'hFFFF_FFFE);
        #1;
        nChecks++; if (jumpAmount !== 32'h200) $display("FAIL br_jump_prio_amt: got %h expected %h", jumpAmount, 32'h200); else nPass++;
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        nChecks++; if (pc !== 32'h200 || flush !== 1'b1) $display("FAIL br_jump_prio: got pc=%h flush=%b expected 200/1", pc, flush); else nPass++;
        tick();
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 32'h3C, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        drive(1'b1, 1'b1, 32'h300, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            nChecks++; if (select !== 1'b0) $display("FAIL stall_select%0d: got %b expected 0", i, select); else nPass++;
            tick();
            nChecks++; if (pc !== 32'h40 || busy !== 1'b1) $display("FAIL stall_hold%0d: got pc=%h busy=%b expected 40/1", i, pc, busy); else nPass++;
        end
        stall = 1'b0;
        #1;
        nChecks++; if (select !== 1'b1) $display("FAIL stall_release_sel: got %b expected 1", select); else nPass++;
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        nChecks++; if (pc !== 32'h300 || flush !== 1'b1) $display("FAIL stall_release_pc: got pc=%h flush=%b expected 300/1", pc, flush); else nPass++;
        tick();
    endtask

    task automatic test_flush_stall();
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b1, 32'h10);
        for (int i = 0; i < 2; i++) begin
            #1;
            nChecks++; if (select !== 1'b0) $display("FAIL fst_select%0d: got %b expected 0", i, select); else nPass++;
            tick();
            nChecks++; if (pc !== 32'hFFFF_FFFC || flush !== 1'b1) $display("FAIL fst_hold%0d: got pc=%h flush=%b expected fffffffc/1", i, pc, flush); else nPass++;
        end
        stall = 1'b0;
        #1;
        nChecks++; if (select !== 1'b0 || pcPlusFour !== 32'h0) $display("FAIL fst_release: got select=%b ppf=%h expected 0/0", select, pcPlusFour); else nPass++;
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        nChecks++; if (pc !== 32'h0 || flush !== 1'b0) $display("FAIL fst_wrap: got pc=%h flush=%b expected 0/0", pc, flush); else nPass++;
    endtask

    task automatic test_random();
        logic [31:0] mPc;
        logic        mFlush;
        logic        mHeld;
        logic        rst, st, j, b, acc;
        logic [31:0] jt, bo, ePlus, eTgt;
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        reset = 1'b0;
        mPc = 32'h0; mFlush = 1'b0; mHeld = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            st  = ($urandom_range(0, 3) == 0);
            j   = ($urandom_range(0, 6) == 0);
            b   = ($urandom_range(0, 5) == 0);
            jt  = $urandom;
            bo  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
            reset = rst;
            drive(st, j, jt, b, bo);
            #1;
            ePlus = mPc + 32'd4;
            eTgt  = j ? {jt[31:2], 2'b00} : ePlus + bo * 32'd4;
            acc   = !mFlush && !st && (j || b);
            nChecks++; if (pcPlusFour !== ePlus) $display("FAIL rnd_ppf@%0d: got %h expected %h", n, pcPlusFour, ePlus); else nPass++;
            nChecks++; if (jumpAmount !== eTgt) $display("FAIL rnd_amt@%0d: got %h expected %h", n, jumpAmount, eTgt); else nPass++;
            nChecks++; if (select !== acc) $display("FAIL rnd_sel@%0d: got %b expected %b", n, select, acc); else nPass++;
            nChecks++; if (flush !== mFlush) $display("FAIL rnd_flush@%0d: got %b expected %b", n, flush, mFlush); else nPass++;
            nChecks++; if (busy !== (mFlush || mHeld)) $display("FAIL rnd_busy@%0d: got %b expected %b", n, busy, mFlush || mHeld); else nPass++;
            if (rst) begin
                mPc = 32'h0; mFlush = 1'b0; mHeld = 1'b0;
            end else if (st) begin
                if (!mFlush) mHeld = 1'b1;
            end else begin
                mPc    = acc ? eTgt : ePlus;
                mFlush = acc;
                mHeld  = 1'b0;
            end
            tick();
            nChecks++; if (pc !== mPc) $display("FAIL rnd_pc@%0d: got %h expected %h", n, pc, mPc); else nPass++;
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
    endtask
`else
    task automatic test_delay();
        tick();
        nChecks++; if (pc !== 32'h10) $display("FAIL dly_start: got %h expected %h", pc, 32'h10); else nPass++;
        drive(1'b0, 1'b1, 32'h80, 1'b0, '0);
        #1;
        nChecks++; if (select !== 1'b0) $display("FAIL dly_acc_sel: got %b expected 0", select); else nPass++;
        tick();
        nChecks++; if (pc !== 32'h14 || flush !== 1'b0 || busy !== 1'b1) $display("FAIL dly_slot: got pc=%h flush=%b busy=%b expected 14/0/1", pc, flush, busy); else nPass++;
        drive(1'b1, 1'b1, 32'h400, 1'b0, '0);
        tick();
        nChecks++; if (pc !== 32'h14) $display("FAIL dly_stall: got %h expected %h", pc, 32'h14); else nPass++;
        stall = 1'b0;
        #1;
        nChecks++; if (select !== 1'b1 || jumpAmount !== 32'h80) $display("FAIL dly_take: got sel=%b amt=%h expected 1/80", select, jumpAmount); else nPass++;
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        nChecks++; if (pc !== 32'h80 || flush !== 1'b0 || busy !== 1'b0) $display("FAIL dly_land: got pc=%h flush=%b busy=%b expected 80/0/0", pc, flush, busy); else nPass++;
        drive(1'b0, 1'b0, '0, 1'b1, 32'h10);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        nChecks++; if (pc !== 32'h84) $display("FAIL dly_br_slot: got %h expected %h", pc, 32'h84); else nPass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nChecks++; if (pc !== 32'h0 || busy !== 1'b0) $display("FAIL dly_reset: got pc=%h busy=%b expected 0/0", pc, busy); else nPass++;
        #1;
        nChecks++; if (select !== 1'b0) $display("FAIL dly_discard_sel: got %b expected 0", select); else nPass++;
        tick();
        nChecks++; if (pc !== 32'h4) $display("FAIL dly_discard_pc: got %h expected %h", pc, 32'h4); else nPass++;
    endtask
`endif

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        test_reset();
        test_sequential();
`ifndef DELAY_SLOT_EN
        test_jump();
        test_branch();
        test_stall();
        test_flush_stall();
        test_random();
`else
        test_delay();
`endif
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
